// File: rtl/sfft_readout_buffer.sv
// sfft_readout_buffer: double-buffered SFFT frame snapshot with tagged,
// drop-counted, little-endian byte readout for the host bus.
module sfft_readout_buffer #(
  parameter int unsigned NFFT          = 256,
  parameter int unsigned BIN_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NFFT*BIN_WIDTH-1:0] bins_in,
  input  logic                      bins_valid,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic [ADDR_WIDTH-1:0]     address,
  output logic [7:0]                readdata,
  output logic                      frame_avail
);

  localparam int unsigned FRAME_BITS  = NFFT * BIN_WIDTH;
  localparam int unsigned FRAME_BYTES = FRAME_BITS / 8;
  localparam int unsigned BIT_IDX_W   = $clog2(FRAME_BITS);
  localparam int unsigned HDR_BYTES   = 8;
  localparam int unsigned FRAME_END   = HDR_BYTES + FRAME_BYTES;

  logic [FRAME_BITS-1:0]    bank0_q, bank1_q;
  logic [COUNTER_WIDTH-1:0] tag0_q, tag1_q;
  logic [COUNTER_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [COUNTER_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                     front_sel_q, front_sel_d;
  logic                     pending_q, pending_d;
  logic                     frame_avail_q, frame_avail_d;
  logic [7:0]               readdata_q, readdata_d;

  logic                     swap_c;
  logic                     host_rd_c;
  logic [FRAME_BITS-1:0]    front_bank_c;
  logic [COUNTER_WIDTH-1:0] front_tag_c;
  logic [31:0]              tag_ext_c, drop_ext_c;
  logic [ADDR_WIDTH-1:0]    byte_off_c;
  logic [BIT_IDX_W-1:0]     bit_idx_c;
  logic [7:0]               rd_byte_c;

  // Host-visible bank and byte-address decode; headers zero-extend to 32 bits
  // so bytes beyond the counter width naturally read 0.
  always_comb begin
    front_bank_c = front_sel_q ? bank1_q : bank0_q;
    front_tag_c  = front_sel_q ? tag1_q  : tag0_q;
    tag_ext_c    = 32'(front_tag_c);
    drop_ext_c   = 32'(drop_count_q);
    byte_off_c   = address - ADDR_WIDTH'(HDR_BYTES);
    bit_idx_c    = BIT_IDX_W'({byte_off_c, 3'b000});
    rd_byte_c    = 8'h00;
    if (address < ADDR_WIDTH'(4)) begin
      rd_byte_c = tag_ext_c[{address[1:0], 3'b000} +: 8];
    end else if (address < ADDR_WIDTH'(HDR_BYTES)) begin
      rd_byte_c = drop_ext_c[{address[1:0], 3'b000} +: 8];
    end else if (address < ADDR_WIDTH'(FRAME_END)) begin
      rd_byte_c = front_bank_c[bit_idx_c +: 8];
    end
  end

  // Swap, capture bookkeeping, drop counting and readout next-state.
  always_comb begin
    swap_c        = pending_q & ~chipselect;
    host_rd_c     = chipselect & read;
    front_sel_d   = front_sel_q ^ swap_c;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    pending_d     = pending_q & ~swap_c;
    frame_avail_d = frame_avail_q;
    readdata_d    = readdata_q;
    if (bins_valid) begin
      frame_count_d = frame_count_q + COUNTER_WIDTH'(1);
      pending_d     = 1'b1;
      if (pending_q && !swap_c && (drop_count_q != '1)) begin
        drop_count_d = drop_count_q + COUNTER_WIDTH'(1);
      end
    end
    if (host_rd_c) begin
      readdata_d = rd_byte_c;
      if (address == '0) frame_avail_d = 1'b0;
    end
    if (swap_c) frame_avail_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
      front_sel_q   <= 1'b0;
      pending_q     <= 1'b0;
      frame_avail_q <= 1'b0;
      readdata_q    <= 8'h00;
    end else begin
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      front_sel_q   <= front_sel_d;
      pending_q     <= pending_d;
      frame_avail_q <= frame_avail_d;
      readdata_q    <= readdata_d;
    end
  end

  // Capture into whichever bank is the back bank after this edge's swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank0_q <= '0;
      bank1_q <= '0;
      tag0_q  <= '0;
      tag1_q  <= '0;
    end else if (bins_valid) begin
      if (front_sel_d) begin
        bank0_q <= bins_in;
        tag0_q  <= frame_count_d;
      end else begin
        bank1_q <= bins_in;
        tag1_q  <= frame_count_d;
      end
    end
  end

  assign readdata    = readdata_q;
  assign frame_avail = frame_avail_q;

endmodule

// File: tb/tb_sfft_readout_buffer.sv
// Testbench for sfft_readout_buffer: randomized traffic against a frame-level
// reference model, plus a reduced-size instance for counter saturation.
module tb_sfft_readout_buffer;

  localparam int N = 256;

  logic             clk;
  logic             reset;
  logic [N*32-1:0]  bins_in;
  logic             bv, cs, rd;
  logic [15:0]      addr;
  logic [7:0]       readdata;
  logic             frame_avail;

  logic [31:0]      s_bins;
  logic             s_bv, s_cs, s_rd;
  logic [7:0]       s_addr;
  logic [7:0]       s_readdata;
  logic             s_avail;

  int checks;
  int failures;

  // Reference model: published frame, latest captured frame, counters.
  int unsigned m_front [N];
  int unsigned m_pend  [N];
  int unsigned cb      [N];
  int unsigned m_ftag, m_ptag, m_fc, m_drop;
  bit          m_pending, m_avail;
  logic [7:0]  m_rd;

  sfft_readout_buffer dut (
    .clk(clk), .reset(reset), .bins_in(bins_in), .bins_valid(bv),
    .chipselect(cs), .read(rd), .address(addr),
    .readdata(readdata), .frame_avail(frame_avail)
  );

  sfft_readout_buffer #(.NFFT(4), .BIN_WIDTH(8), .ADDR_WIDTH(8), .COUNTER_WIDTH(8)) dut_s (
    .clk(clk), .reset(reset), .bins_in(s_bins), .bins_valid(s_bv),
    .chipselect(s_cs), .read(s_rd), .address(s_addr),
    .readdata(s_readdata), .frame_avail(s_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_byte(input int unsigned a);
    int unsigned j;
    if (a < 4) return 8'(m_ftag >> (8 * a));
    if (a < 8) return 8'(m_drop >> (8 * (a - 4)));
    if (a < 8 + N * 4) begin
      j = a - 8;
      return 8'(m_front[j / 4] >> (8 * (j % 4)));
    end
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_front[i] = 0;
      m_pend[i]  = 0;
    end
    m_ftag = 0; m_ptag = 0; m_fc = 0; m_drop = 0;
    m_pending = 0; m_avail = 0; m_rd = 8'h00;
  endtask

  task automatic load_bins();
    for (int i = 0; i < N; i++) bins_in[i*32 +: 32] = cb[i];
  endtask

  task automatic random_frame();
    for (int i = 0; i < N; i++) cb[i] = $urandom;
    load_bins();
  endtask

  task automatic idle();
    bv = 1'b0; cs = 1'b0; rd = 1'b0; addr = 16'h0;
    s_bv = 1'b0; s_cs = 1'b0; s_rd = 1'b0; s_addr = 8'h0;
  endtask

  // One clock edge; the model applies the same inputs, then outputs settle.
  task automatic step();
    bit sw;
    @(posedge clk);
    sw = m_pending && !cs;
    if (cs && rd) begin
      m_rd = exp_byte(32'(addr));
      if (addr == 16'h0) m_avail = 0;
    end
    if (sw) begin
      m_front   = m_pend;
      m_ftag    = m_ptag;
      m_avail   = 1;
      m_pending = 0;
    end
    if (bv) begin
      m_fc = m_fc + 1;
      if (m_pending && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
      m_pend    = cb;
      m_ptag    = m_fc;
      m_pending = 1;
    end
    #1;
  endtask

  task automatic do_read(input int a);
    cs = 1'b1; rd = 1'b1; addr = 16'(a);
    step();
  endtask

  task automatic s_read(input int a);
    s_cs = 1'b1; s_rd = 1'b1; s_addr = 8'(a);
    step();
  endtask

  task automatic test_reset();
    idle();
    random_frame();
    bv = 1'b1; step(); bv = 1'b0; step();
    do_read(8); idle();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (readdata !== 8'h00) begin failures++; $display("FAIL reset_readdata: got %0h exp 0", readdata); end
    checks++;
    if (frame_avail !== 1'b0) begin failures++; $display("FAIL reset_avail: got %0b exp 0", frame_avail); end
    checks++;
    if (s_readdata !== 8'h00 || s_avail !== 1'b0) begin
      failures++; $display("FAIL reset_small: got %0h/%0b exp 0/0", s_readdata, s_avail);
    end
    @(negedge clk); reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      do_read(a);
      checks++;
      if (readdata !== 8'h00) begin failures++; $display("FAIL reset_hdr[%0d]: got %0h exp 0", a, readdata); end
    end
    idle();
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_b [8];
    int         ad    [8];
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'hA5, 8'h01};
    ad    = '{1, 2, 3, 20, 21, 22, 23, 0};
    idle();
    for (int i = 0; i < N; i++) cb[i] = 32'hA500_0000 + 32'(i);
    load_bins();
    bv = 1'b1; step(); bv = 1'b0;
    checks++;
    if (frame_avail !== 1'b0) begin failures++; $display("FAIL single_avail_t1: got %0b exp 0", frame_avail); end
    step();
    checks++;
    if (frame_avail !== 1'b1) begin failures++; $display("FAIL single_avail_t2: got %0b exp 1", frame_avail); end
    for (int n = 0; n < 8; n++) begin
      do_read(ad[n]);
      checks++;
      if (readdata !== exp_b[n]) begin
        failures++; $display("FAIL single_byte[%0d]: got %0h exp %0h", ad[n], readdata, exp_b[n]);
      end
    end
    checks++;
    if (frame_avail !== 1'b0) begin failures++; $display("FAIL single_avail_clr: got %0b exp 0", frame_avail); end
    idle();
  endtask

  task automatic test_deferred();
    int a;
    idle();
    random_frame();
    for (int c = 0; c < 20; c++) begin
      bv = (c == 5);
      do_read(0);
      checks++;
      if (readdata !== 8'h01 || readdata !== m_rd) begin
        failures++; $display("FAIL deferred_tag[c%0d]: got %0h exp 01", c, readdata);
      end
    end
    bv = 1'b0; cs = 1'b0; rd = 1'b0;
    checks++;
    if (frame_avail !== 1'b0) begin failures++; $display("FAIL deferred_held: got %0b exp 0", frame_avail); end
    step();
    checks++;
    if (frame_avail !== 1'b1) begin failures++; $display("FAIL deferred_swap: got %0b exp 1", frame_avail); end
    do_read(0);
    checks++;
    if (readdata !== 8'h02) begin failures++; $display("FAIL deferred_newtag: got %0h exp 02", readdata); end
    do_read(4);
    checks++;
    if (readdata !== 8'h00) begin failures++; $display("FAIL deferred_drop: got %0h exp 00", readdata); end
    for (int n = 0; n < 4; n++) begin
      a = 8 + $urandom_range(1023);
      do_read(a);
      checks++;
      if (readdata !== m_rd) begin failures++; $display("FAIL deferred_bin[%0d]: got %0h exp %0h", a, readdata, m_rd); end
    end
    idle();
  endtask

  task automatic test_drop();
    int unsigned third [N];
    int          a;
    logic [7:0]  e;
    idle();
    cs = 1'b1;
    random_frame(); bv = 1'b1; step(); bv = 1'b0; step(); step();
    random_frame(); bv = 1'b1; step();
    random_frame(); third = cb; step();
    bv = 1'b0; cs = 1'b0;
    step();
    do_read(0);
    checks++;
    if (readdata !== 8'h05) begin failures++; $display("FAIL drop_tag: got %0h exp 05", readdata); end
    do_read(4);
    checks++;
    if (readdata !== 8'h02) begin failures++; $display("FAIL drop_count: got %0h exp 02", readdata); end
    for (int n = 0; n < 6; n++) begin
      a = 8 + $urandom_range(1023);
      e = 8'(third[(a - 8) / 4] >> (8 * ((a - 8) % 4)));
      do_read(a);
      checks++;
      if (readdata !== e) begin failures++; $display("FAIL drop_bin[%0d]: got %0h exp %0h", a, readdata, e); end
    end
    idle();
  endtask

  task automatic test_simultaneous();
    int unsigned fn1 [N];
    int          a;
    logic [7:0]  e;
    idle();
    random_frame();
    bv = 1'b1; do_read(0);
    checks++;
    if (readdata !== 8'h05) begin failures++; $display("FAIL simul_old: got %0h exp 05", readdata); end
    cs = 1'b0; rd = 1'b0;
    random_frame(); fn1 = cb;
    step();
    bv = 1'b0;
    checks++;
    if (frame_avail !== 1'b1) begin failures++; $display("FAIL simul_swap1: got %0b exp 1", frame_avail); end
    do_read(0);
    checks++;
    if (readdata !== 8'h06) begin failures++; $display("FAIL simul_frameN: got %0h exp 06", readdata); end
    cs = 1'b0; rd = 1'b0;
    step();
    checks++;
    if (frame_avail !== 1'b1) begin failures++; $display("FAIL simul_swap2: got %0b exp 1", frame_avail); end
    do_read(0);
    checks++;
    if (readdata !== 8'h07) begin failures++; $display("FAIL simul_frameN1: got %0h exp 07", readdata); end
    do_read(4);
    checks++;
    if (readdata !== 8'h02) begin failures++; $display("FAIL simul_drop: got %0h exp 02", readdata); end
    a = 8 + $urandom_range(1023);
    e = 8'(fn1[(a - 8) / 4] >> (8 * ((a - 8) % 4)));
    do_read(a);
    checks++;
    if (readdata !== e) begin failures++; $display("FAIL simul_bin[%0d]: got %0h exp %0h", a, readdata, e); end
    idle();
  endtask

  task automatic test_boundary();
    logic [7:0] e;
    e = 8'(m_front[255] >> 24);
    do_read(8 + N * 4 - 1);
    checks++;
    if (readdata !== e) begin failures++; $display("FAIL bound_last: got %0h exp %0h", readdata, e); end
    do_read(8 + N * 4);
    checks++;
    if (readdata !== 8'h00) begin failures++; $display("FAIL bound_past: got %0h exp 00", readdata); end
    do_read(16'hFFFF);
    checks++;
    if (readdata !== 8'h00) begin failures++; $display("FAIL bound_ffff: got %0h exp 00", readdata); end
    idle();
  endtask

  task automatic test_random();
    idle();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) cs = ~cs;
      rd = 1'($urandom);
      case ($urandom_range(3))
        0:       addr = 16'($urandom_range(7));
        1, 2:    addr = 16'(8 + $urandom_range(1023));
        default: addr = 16'($urandom);
      endcase
      bv = ($urandom_range(4) == 0);
      if (bv) random_frame();
      step();
      checks++;
      if (readdata !== m_rd || frame_avail !== m_avail) begin
        failures++;
        $display("FAIL random[c%0d]: got %0h/%0b exp %0h/%0b", c, readdata, frame_avail, m_rd, m_avail);
      end
    end
    idle();
  endtask

  task automatic test_saturation();
    logic [31:0] last;
    idle();
    s_cs = 1'b1;
    for (int c = 0; c < 300; c++) begin
      s_bins = $urandom; s_bv = 1'b1;
      step();
    end
    s_bv = 1'b0; s_cs = 1'b0;
    step();
    s_read(4);
    checks++;
    if (s_readdata !== 8'hFF) begin failures++; $display("FAIL sat_drop: got %0h exp ff", s_readdata); end
    s_read(0);
    checks++;
    if (s_readdata !== 8'h2C) begin failures++; $display("FAIL sat_tag: got %0h exp 2c", s_readdata); end
    s_read(1);
    checks++;
    if (s_readdata !== 8'h00) begin failures++; $display("FAIL sat_tag_hi: got %0h exp 00", s_readdata); end
    s_read(5);
    checks++;
    if (s_readdata !== 8'h00) begin failures++; $display("FAIL sat_drop_hi: got %0h exp 00", s_readdata); end
    s_rd = 1'b0;
    s_bins = $urandom; s_bv = 1'b1; step();
    s_bins = $urandom; last = s_bins; step();
    s_bv = 1'b0; s_cs = 1'b0;
    step();
    s_read(4);
    checks++;
    if (s_readdata !== 8'hFF) begin failures++; $display("FAIL sat_hold: got %0h exp ff", s_readdata); end
    s_read(0);
    checks++;
    if (s_readdata !== 8'h2E) begin failures++; $display("FAIL sat_tag2: got %0h exp 2e", s_readdata); end
    s_read(10);
    checks++;
    if (s_readdata !== last[23:16]) begin failures++; $display("FAIL sat_bin2: got %0h exp %0h", s_readdata, last[23:16]); end
    s_read(12);
    checks++;
    if (s_readdata !== 8'h00) begin failures++; $display("FAIL sat_past: got %0h exp 00", s_readdata); end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bins_in = '0;
    s_bins = '0;
    idle();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_frame();
    test_deferred();
    test_drop();
    test_simultaneous();
    test_boundary();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfft_readout_buffer.md
# sfft_readout_buffer

Double-buffered snapshot and byte-readout block between the SFFT pipeline and the host bus interface. Captures a full frame of `NFFT` bin magnitudes on each pipeline valid pulse into a back bank and swaps it to the host-visible front bank only when the host is not mid-access, so a burst read never sees a torn frame. It tags each frame with a running frame index and counts frames dropped while the host held the bus. It serves the frame, byte by byte, with a fixed little-endian byte order.

## Interface
- `NFFT`, 256: number of bins per frame (≥2).
- `BIN_WIDTH`, 32: bits per bin; multiple of 8, ≤32.
- `ADDR_WIDTH`, 16: host byte-address width; must cover `8 + NFFT*BIN_WIDTH/8` bytes.
- `COUNTER_WIDTH`, 32: frame-index and drop-counter width; multiple of 8, ≤32.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `bins_in` in `NFFT*BIN_WIDTH`: flattened frame; bin i at `[i*BIN_WIDTH +: BIN_WIDTH]`.
- `bins_valid` in 1: one-cycle pulse; `bins_in` valid in the same cycle.
- `chipselect` in 1: high for the duration of a host access burst.
- `read` in 1: host read strobe; meaningful only with `chipselect`.
- `address` in `ADDR_WIDTH`: host byte address.
- `readdata` out 8: registered read byte.
- `frame_avail` out 1: level; a new frame has been swapped to the front bank and header byte 0 has not been read since.

## Operation
- Storage is two banks, each holding `NFFT` bins plus a `COUNTER_WIDTH` frame tag. `front_sel` selects the host-visible bank.
- `frame_count` increments, with wrap, on every `bins_valid`. The captured frame's tag is the incremented value, so the first frame is tagged 1 and tag 0 means no frame yet.
- Capture: on `bins_valid`, write `bins_in` and the tag into the back bank and set `pending`.
- Swap condition: `pending`=1 and `chipselect`=0 in the same cycle. On that edge:
  - toggle `front_sel`;
  - clear `pending`;
  - set `frame_avail`.
- Simultaneous swap and `bins_valid`: the swap executes, the new frame is written into the new back bank (the old front bank), and `pending` stays 1. This is not a drop.
- `bins_valid` while `pending`=1 and no swap that cycle: overwrite the back bank (newest frame wins) and increment `drop_count`. `drop_count` saturates at all-ones and does not wrap.
- Byte address map, little-endian within each field:
  - 0..3: front-bank frame tag. Bytes at or beyond `COUNTER_WIDTH/8` read 0.
  - 4..7: `drop_count`, same rule.
  - `8 + i*B + k`, with `B = BIN_WIDTH/8`: byte k of front bin i.
  - Any other address reads 0.
- Read: a cycle with `chipselect`=1 and `read`=1 loads `readdata` on that edge. Otherwise `readdata` holds.
- `frame_avail` clears on a read of address 0. If a swap occurs on the same edge, set wins.
- Reset, including mid-burst: both banks and tags 0, `frame_count`=0, `drop_count`=0, `pending`=0, `front_sel`=0, `readdata`=0, `frame_avail`=0.

## Timing
- `bins_valid` in cycle t sets `pending` at edge t.
- Earliest swap is edge t+1, if `chipselect` is low in cycle t+1.
- A read issued in cycle t+2 returns new-frame data in `readdata` from cycle t+3.
- Read latency is 1 cycle: address/strobe at edge n gives `readdata` valid after edge n.
- While `chipselect`=1, the front bank is frozen for any burst length. `pending` persists across the burst.
- The swap occurs on the first edge with `chipselect`=0.
- Capture takes 1 cycle. Back-to-back `bins_valid` on consecutive cycles is legal; each pulse is captured or counted as a drop.
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle. Outputs go to 0 immediately, and a read of addresses 0..7 returns 0.
- Single frame, NFFT=256, BIN_WIDTH=32, bin i = 0xA5000000+i, `chipselect` low:
  - `frame_avail`=1 at cycle t+2;
  - bytes 0..3 read 01 00 00 00;
  - address 8+4*3 = 20..23 reads 03 00 00 A5;
  - address 0 read clears `frame_avail`.
- Deferred swap: hold `chipselect`=1 for 20 cycles and pulse `bins_valid` at cycle 5. Reads keep returning the old tag. The swap occurs on the first edge after `chipselect` drops; `drop_count` stays 0.
- Drop: with `chipselect`=1, pulse `bins_valid` 3 times.
  - After release, the tag reads 3 and `drop_count` reads 2.
  - Bins equal the third frame.
- Simultaneous: with `pending`=1, `chipselect`=0 and `bins_valid` in the same cycle:
  - the front shows frame N;
  - `pending` stays 1;
  - the next edge swaps to frame N+1;
  - `drop_count` is unchanged.
- Boundary: addresses `8+NFFT*4-1`, `8+NFFT*4` and 0xFFFF read bin 255 byte 3, 0 and 0. A `drop_count` forced to all-ones stays all-ones on a further drop.
